parity_stream_out: RTL and testbench



---
 rtl/ldpc_enc_pkg.sv | 18 +
 rtl/parity_skid_fifo.sv | 56 +++++
 rtl/parity_stream_out.sv | 137 +++++++++++++
 tb/tb_parity_stream_out.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_enc_pkg.sv
// Shared definitions for the LDPC encoder parity path: default sizes,
// buffer address width, parity word type and read-out FSM states.
package ldpc_enc_pkg;

  localparam int DEF_MAX_ZC              = 384;
  localparam int DEF_MUL_SH_BLOCKS_COUNT = 23;
  localparam int PBUF_ADDR_W             = 9;

  typedef logic [DEF_MAX_ZC-1:0] parity_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pso_state_e;

endpackage

// File: rtl/parity_skid_fifo.sv
// Two-entry register FIFO that lets the read-out keep one word per cycle
// while absorbing the one-cycle buffer read latency under back-pressure.
module parity_skid_fifo
  import ldpc_enc_pkg::*;
#(
  parameter int WIDTH = DEF_MAX_ZC
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [0:1];
  logic [WIDTH-1:0] mem_d [0:1];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  // Callers only push when a slot is free and only pop when non-empty.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/parity_stream_out.sv
// Parity buffer read-out: issues buffer reads, captures the returned words
// and streams them over valid/ready with a 2-entry skid FIFO.
module parity_stream_out
  import ldpc_enc_pkg::*;
#(
  parameter int MAX_ZC              = DEF_MAX_ZC,
  parameter int MUL_SH_BLOCKS_COUNT = DEF_MUL_SH_BLOCKS_COUNT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [4:0]             num_parity,
  input  logic [MAX_ZC-1:0]      parity_in,
  output logic                   rd_en,
  output logic [PBUF_ADDR_W-1:0] rd_address,
  output logic [MAX_ZC-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
);

  localparam logic [4:0] MAX_BLOCKS = 5'(MUL_SH_BLOCKS_COUNT);

  pso_state_e state_q, state_d;
  logic [4:0] n_q, n_d;
  logic [4:0] rd_idx_q, rd_idx_d;
  logic [4:0] beat_idx_q, beat_idx_d;
  logic       cfg_pend_q, cfg_pend_d;
  logic       inflight_q, inflight_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       cfg_err_q, cfg_err_d;

  logic [1:0] fifo_count;
  logic       pop;
  logic [2:0] occupancy;
  logic [4:0] n_clamped;

  parity_skid_fifo #(
    .WIDTH (MAX_ZC)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (inflight_q),
    .push_data (parity_in),
    .pop       (pop),
    .head      (out_data),
    .count     (fifo_count)
  );

  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_last  = out_valid & (beat_idx_q == n_q - 5'd1);

  // Words held plus the one in flight, net of this cycle's pop, must leave a
  // free slot for the word a new read will return next cycle.
  assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en      = (state_q == READ) && (occupancy < 3'd2);
  assign rd_address = (state_q == READ) ? PBUF_ADDR_W'(rd_idx_q) : '0;
  assign n_clamped  = (num_parity > MAX_BLOCKS) ? MAX_BLOCKS : num_parity;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    rd_idx_d   = rd_idx_q;
    beat_idx_d = pop ? beat_idx_q + 5'd1 : beat_idx_q;
    cfg_pend_d = cfg_pend_q;
    inflight_d = rd_en;

    case (state_q)
      IDLE: begin
        if (start) begin
          n_d        = n_clamped;
          cfg_pend_d = (num_parity > MAX_BLOCKS);
          rd_idx_d   = 5'd0;
          beat_idx_d = 5'd0;
          // An empty read-out passes through DRAIN so done lands two cycles after start.
          state_d    = (n_clamped == 5'd0) ? DRAIN : READ;
        end
      end
      READ: begin
        if (rd_en) begin
          rd_idx_d = rd_idx_q + 5'd1;
          if (rd_idx_q == n_q - 5'd1) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!inflight_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        cfg_pend_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    cfg_err_d = (state_d == DONE) && cfg_pend_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      n_q        <= 5'd0;
      rd_idx_q   <= 5'd0;
      beat_idx_q <= 5'd0;
      cfg_pend_q <= 1'b0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      rd_idx_q   <= rd_idx_d;
      beat_idx_q <= beat_idx_d;
      cfg_pend_q <= cfg_pend_d;
      inflight_q <= inflight_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_parity_stream_out.sv
// Directed bench for parity_stream_out with a registered-read buffer model
// holding word k = k+1.
module tb_parity_stream_out;
  localparam int MAX_ZC = 384;
  localparam int NBLK   = 23;

  logic              clk, reset_n, start, out_ready;
  logic [4:0]        num_parity;
  logic [MAX_ZC-1:0] parity_in;
  logic              rd_en, out_valid, out_last, busy, done, cfg_err;
  logic [8:0]        rd_address;
  logic [MAX_ZC-1:0] out_data;

  parity_stream_out #(.MAX_ZC(MAX_ZC), .MUL_SH_BLOCKS_COUNT(NBLK)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_parity(num_parity),
    .parity_in(parity_in), .rd_en(rd_en), .rd_address(rd_address),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [MAX_ZC-1:0] bufm [0:511];
  initial begin
    for (int k = 0; k < 512; k++) bufm[k] = MAX_ZC'(k + 1);
    parity_in = '0;
  end
  always @(posedge clk) if (rd_en) parity_in <= bufm[rd_address];

  int checks = 0;
  int errors = 0;

  logic [MAX_ZC-1:0] got_w [0:63];
  int got_cyc [0:63];
  int rd_addr_l [0:63];
  int rd_cyc_l [0:63];
  int got_n, rd_cnt, last_cnt, last_idx, done_cyc, valid_seen, stall_chg;
  logic cfg_at_done;

  task automatic start_readout(input logic [4:0] np);
    @(negedge clk);
    num_parity = np;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // mode 0: ready high; 1: ready toggles; 2: ready low for cycles 1..10
  task automatic capture(input int mode, input int max_cyc, input int restart_cyc);
    logic stalled;
    logic [MAX_ZC-1:0] held;
    got_n = 0; rd_cnt = 0; last_cnt = 0; last_idx = -1; done_cyc = -1;
    valid_seen = 0; stall_chg = 0; cfg_at_done = 1'b0; stalled = 1'b0; held = '0;
    for (int c = 1; c <= max_cyc; c++) begin
      case (mode)
        1:       out_ready = c[0];
        2:       out_ready = (c > 10);
        default: out_ready = 1'b1;
      endcase
      if (restart_cyc != 0 && c == restart_cyc) begin
        start = 1'b1; num_parity = 5'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (rd_en && rd_cnt < 64) begin
        rd_addr_l[rd_cnt] = int'(rd_address); rd_cyc_l[rd_cnt] = c; rd_cnt++;
      end
      if (stalled && out_data !== held) stall_chg++;
      stalled = out_valid && !out_ready;
      held = out_data;
      if (out_valid) begin
        valid_seen++;
        if (out_ready && got_n < 64) begin
          got_w[got_n] = out_data; got_cyc[got_n] = c;
          if (out_last) begin last_cnt++; last_idx = got_n; end
          got_n++;
        end
      end
      if (done) begin done_cyc = c; cfg_at_done = cfg_err; break; end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if ({rd_en, out_valid, out_last, busy, done, cfg_err} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 000000", {rd_en, out_valid, out_last, busy, done, cfg_err}); end
    checks++; if (rd_address !== 9'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", rd_address); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %0h want 0", out_data); end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    start_readout(5'd4);
    capture(0, 40, 0);
    checks++; if (rd_cnt !== 4) begin errors++; $display("FAIL basic_rd_cnt: got %0d want 4", rd_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_addr_l[i] !== i || rd_cyc_l[i] !== i + 1) begin errors++; $display("FAIL basic_rd[%0d]: addr %0d cyc %0d want addr %0d cyc %0d", i, rd_addr_l[i], rd_cyc_l[i], i, i + 1); end
    end
    checks++; if (got_n !== 4) begin errors++; $display("FAIL basic_words: got %0d want 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_w[i] !== MAX_ZC'(i + 1) || got_cyc[i] !== i + 3) begin errors++; $display("FAIL basic_word[%0d]: data %0h cyc %0d want data %0h cyc %0d", i, got_w[i], got_cyc[i], i + 1, i + 3); end
    end
    checks++; if (last_cnt !== 1 || last_idx !== 3) begin errors++; $display("FAIL basic_last: cnt %0d idx %0d want 1 / 3", last_cnt, last_idx); end
    checks++; if (done_cyc !== 7 || cfg_at_done !== 1'b0) begin errors++; $display("FAIL basic_done: cyc %0d cfg %b want 7 / 0", done_cyc, cfg_at_done); end
  endtask

  task automatic test_toggle();
    int bad;
    start_readout(5'd23);
    capture(1, 200, 0);
    bad = 0;
    for (int i = 0; i < 23; i++) if (got_w[i] !== MAX_ZC'(i + 1)) bad++;
    checks++; if (got_n !== 23) begin errors++; $display("FAIL toggle_words: got %0d want 23", got_n); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL toggle_order: %0d wrong words want 0", bad); end
    checks++; if (stall_chg !== 0) begin errors++; $display("FAIL toggle_stable: %0d changes during stall want 0", stall_chg); end
    checks++; if (last_cnt !== 1 || last_idx !== 22) begin errors++; $display("FAIL toggle_last: cnt %0d idx %0d want 1 / 22", last_cnt, last_idx); end
    checks++; if (done_cyc < 0) begin errors++; $display("FAIL toggle_done: no done within bound"); end
  endtask

  task automatic test_clamp();
    start_readout(5'd30);
    capture(0, 80, 0);
    checks++; if (got_n !== 23 || rd_cnt !== 23) begin errors++; $display("FAIL clamp_words: words %0d reads %0d want 23 / 23", got_n, rd_cnt); end
    checks++; if (got_w[22] !== MAX_ZC'(23)) begin errors++; $display("FAIL clamp_word22: got %0h want 17", got_w[22]); end
    checks++; if (last_cnt !== 1 || last_idx !== 22) begin errors++; $display("FAIL clamp_last: cnt %0d idx %0d want 1 / 22", last_cnt, last_idx); end
    checks++; if (done_cyc !== 26 || cfg_at_done !== 1'b1) begin errors++; $display("FAIL clamp_done: cyc %0d cfg %b want 26 / 1", done_cyc, cfg_at_done); end
  endtask

  task automatic test_zero();
    start_readout(5'd0);
    capture(0, 20, 0);
    checks++; if (rd_cnt !== 0 || valid_seen !== 0) begin errors++; $display("FAIL zero_activity: reads %0d valids %0d want 0 / 0", rd_cnt, valid_seen); end
    checks++; if (done_cyc !== 2 || cfg_at_done !== 1'b0) begin errors++; $display("FAIL zero_done: cyc %0d cfg %b want 2 / 0", done_cyc, cfg_at_done); end
  endtask

  task automatic test_restart();
    start_readout(5'd5);
    capture(0, 40, 2);
    checks++; if (got_n !== 5 || rd_cnt !== 5) begin errors++; $display("FAIL restart_words: words %0d reads %0d want 5 / 5", got_n, rd_cnt); end
    checks++; if (got_w[4] !== MAX_ZC'(5) || last_idx !== 4) begin errors++; $display("FAIL restart_last: data %0h idx %0d want 5 / 4", got_w[4], last_idx); end
    checks++; if (done_cyc !== 8) begin errors++; $display("FAIL restart_done: cyc %0d want 8", done_cyc); end
  endtask

  task automatic test_backpressure();
    int early, bad;
    start_readout(5'd6);
    capture(2, 60, 0);
    early = 0;
    for (int i = 0; i < rd_cnt; i++) if (rd_cyc_l[i] <= 10) early++;
    bad = 0;
    for (int i = 0; i < 6; i++) if (got_w[i] !== MAX_ZC'(i + 1) || got_cyc[i] !== 11 + i) bad++;
    checks++; if (early !== 2) begin errors++; $display("FAIL bp_reads_stalled: got %0d want 2", early); end
    checks++; if (got_n !== 6 || bad !== 0) begin errors++; $display("FAIL bp_stream: words %0d bad %0d want 6 / 0", got_n, bad); end
    checks++; if (done_cyc !== 17) begin errors++; $display("FAIL bp_done: cyc %0d want 17", done_cyc); end
  endtask

  task automatic test_reset_mid();
    int act;
    out_ready = 1'b1;
    start_readout(5'd5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== MAX_ZC'(3)) begin errors++; $display("FAIL mid_word3: valid %b data %0h want 1 / 3", out_valid, out_data); end
    reset_n = 1'b0;
    #1;
    checks++; if ({rd_en, out_valid, out_last, busy, done, cfg_err} !== 6'b0 || rd_address !== 9'd0 || out_data !== '0) begin errors++; $display("FAIL mid_reset_outputs: ctrl %b addr %0d data %0h want 0", {rd_en, out_valid, out_last, busy, done, cfg_err}, rd_address, out_data); end
    checks++; if (dut.state_q !== ldpc_enc_pkg::IDLE) begin errors++; $display("FAIL mid_reset_state: got %0d want IDLE", dut.state_q); end
    @(negedge clk);
    reset_n = 1'b1;
    act = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || out_last || rd_en || busy || done) act++;
    end
    checks++; if (act !== 0) begin errors++; $display("FAIL mid_after_reset: %0d active cycles want 0", act); end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; num_parity = 5'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic();
    test_toggle();
    test_clamp();
    test_zero();
    test_restart();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
